// File: rtl/ti_sbox_pkg.sv
// Shared definitions for the TI S-box layer controller: sizes, FSM states and
// the nibble addressing helper used to index shared state vectors.
package ti_sbox_pkg;

  localparam int NSHARE = 3;
  localparam int NNIB   = 16;
  localparam int MID_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit offset of nibble idx of share `share` in a shared state vector.
  function automatic int nib_off(input int share, input int idx, input int nnib = NNIB);
    return share * 4 * nnib + idx * 4;
  endfunction

endpackage

// File: rtl/ti_sbox_stage_reg.sv
// Valid-tracked pipeline register; data loads (XORed with mask) only when
// in_vld is set, otherwise it holds. The valid bit follows in_vld each cycle.
module ti_sbox_stage_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] d,
  input  logic [W-1:0] mask,
  output logic [W-1:0] q,
  output logic         vld
);

  logic [W-1:0] data_q, data_d;
  logic         vld_q;

  always_comb begin
    data_d = data_q;
    if (in_vld) data_d = d ^ mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= in_vld;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;

endmodule

// File: rtl/ti_sbox_layer_ctrl.sv
// Sequences one shared S-box layer through an external two-stage TI S-box,
// one nibble per cycle. Define TI_REMASK_EN to add fresh-randomness remasking.
module ti_sbox_layer_ctrl #(
  parameter int NSHARE = ti_sbox_pkg::NSHARE,
  parameter int NNIB   = ti_sbox_pkg::NNIB,
  parameter int MID_W  = ti_sbox_pkg::MID_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NSHARE*4*NNIB-1:0] state_in,
  output logic                     ready,
  output logic                     done,
  output logic [NSHARE*4*NNIB-1:0] state_out,
  output logic [NSHARE*4-1:0]      s1_in,
  input  logic [MID_W-1:0]         s1_out,
  output logic [MID_W-1:0]         s2_in,
`ifdef TI_REMASK_EN
  input  logic [2*(MID_W/NSHARE)-1:0] rnd,
`endif
  input  logic [NSHARE*4-1:0]      s2_out
);
  import ti_sbox_pkg::*;

  localparam int W  = NSHARE * 4 * NNIB;
  localparam int NW = NSHARE * 4;
  localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   feed_cnt_q, feed_cnt_d;
  logic [CW-1:0]   wb_cnt_q, wb_cnt_d;
  logic [W-1:0]    work_q, work_d;
  logic [NW-1:0]   feed_nib;
  logic [MID_W-1:0] mask;
  logic            feed_vld, v1, v2;

  assign feed_vld = (state_q == RUN);

  // Feeding reads nibbles not yet overwritten: writeback trails the feed by 2.
  always_comb begin
    feed_nib = '0;
    for (int s = 0; s < NSHARE; s++)
      feed_nib[s*4 +: 4] = work_q[nib_off(s, int'(feed_cnt_q), NNIB) +: 4];
  end

`ifdef TI_REMASK_EN
  localparam int SL = MID_W / NSHARE;
  // Slice masks r0, r1, r0^r1 cancel in the XOR over shares.
  always_comb begin
    mask = '0;
    mask[0 +: SL]    = rnd[0 +: SL];
    mask[SL +: SL]   = rnd[SL +: SL];
    mask[2*SL +: SL] = rnd[0 +: SL] ^ rnd[SL +: SL];
  end
`else
  assign mask = '0;
`endif

  ti_sbox_stage_reg #(.W(NW)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (feed_vld),
    .d      (feed_nib),
    .mask   ({NW{1'b0}}),
    .q      (s1_in),
    .vld    (v1)
  );

  ti_sbox_stage_reg #(.W(MID_W)) u_s2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (v1),
    .d      (s1_out),
    .mask   (mask),
    .q      (s2_in),
    .vld    (v2)
  );

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    work_d     = work_q;

    if (v2) begin
      for (int s = 0; s < NSHARE; s++)
        work_d[nib_off(s, int'(wb_cnt_q), NNIB) +: 4] = s2_out[s*4 +: 4];
      if (wb_cnt_q != LAST) wb_cnt_d = wb_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: if (start) begin
        work_d     = state_in;
        feed_cnt_d = '0;
        wb_cnt_d   = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (feed_cnt_q == LAST) state_d = DRAIN;
        else                    feed_cnt_d = feed_cnt_q + 1'b1;
      end
      DRAIN: if (v2 && wb_cnt_q == LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feed_cnt_q <= '0;
      wb_cnt_q   <= '0;
      work_q     <= '0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      work_q     <= work_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign state_out = work_q;

endmodule

// File: tb/tb_ti_sbox_layer_ctrl.sv
// Randomized bench for ti_sbox_layer_ctrl with a stub S-box (share0 nibble
// inverted); a cycle-indexed reference model is compared on every negedge.
module tb_ti_sbox_layer_ctrl;
  import ti_sbox_pkg::*;

  localparam int SW = 4 * NNIB;
  localparam int W  = NSHARE * SW;
  localparam int NW = NSHARE * 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     state_in = '0;
  logic [W-1:0]     state_out;
  logic             ready, done;
  logic [NW-1:0]    s1_in, s2_out;
  logic [MID_W-1:0] s1_out, s2_in;
`ifdef TI_REMASK_EN
  logic [2*(MID_W/NSHARE)-1:0] rnd = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stub datapath: stage 1 inverts share 0, stage 2 is a pass-through.
  assign s1_out = MID_W'(s1_in) ^ MID_W'(4'hF);
  assign s2_out = NW'(s2_in);

  ti_sbox_layer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state_in  (state_in),
    .ready     (ready),
    .done      (done),
    .state_out (state_out),
    .s1_in     (s1_in),
    .s1_out    (s1_out),
    .s2_in     (s2_in),
`ifdef TI_REMASK_EN
    .rnd       (rnd),
`endif
    .s2_out    (s2_out)
  );

`ifdef TI_REMASK_EN
  always @(negedge clk) #1 rnd = $urandom;
`endif

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] nib(input logic [W-1:0] x, input int k);
    logic [NW-1:0] r;
    for (int s = 0; s < NSHARE; s++) r[s*4 +: 4] = x[s*SW + k*4 +: 4];
    return r;
  endfunction

  function automatic logic [SW-1:0] fold_st(input logic [W-1:0] x);
    logic [SW-1:0] r = '0;
    for (int s = 0; s < NSHARE; s++) r ^= x[s*SW +: SW];
    return r;
  endfunction

  function automatic logic [3:0] fold_nib(input logic [NW-1:0] x);
    logic [3:0] r = '0;
    for (int s = 0; s < NSHARE; s++) r ^= x[s*4 +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: t = edges since accept; the layer result is share 0 inverted.
  logic          busy = 1'b0;
  int            t = 0;
  logic [W-1:0]  cap = '0, exp_res = '0, exp_state = '0;
  logic [NW-1:0] exp_s1 = '0, exp_s2 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0; t = 0;
      exp_state = '0; exp_s1 = '0; exp_s2 = '0;
    end else if (busy) begin
      t++;
      if (t >= 1 && t <= NNIB) exp_s1 = nib(cap, t-1);
      if (t >= 2 && t <= NNIB+1) exp_s2 = nib(cap, t-2) ^ NW'(4'hF);
      if (t >= 3 && t <= NNIB+2)
        for (int s = 0; s < NSHARE; s++)
          exp_state[s*SW + (t-3)*4 +: 4] = exp_res[s*SW + (t-3)*4 +: 4];
      if (t == NNIB+3) busy = 1'b0;
    end else if (start) begin
      busy = 1'b1; t = 0;
      cap = state_in; exp_state = state_in;
      exp_res = state_in;
      exp_res[SW-1:0] = ~state_in[SW-1:0];
    end
  end

  always @(negedge clk) begin
    chk("ready", W'(ready), W'(!busy));
    chk("done", W'(done), W'(busy && t == NNIB+2));
    chk("s1_in", W'(s1_in), W'(exp_s1));
`ifdef TI_REMASK_EN
    chk("s2_in_fold", W'(fold_nib(NW'(s2_in))), W'(fold_nib(exp_s2)));
    chk("state_out_fold", W'(fold_st(state_out)), W'(fold_st(exp_state)));
`else
    chk("s2_in", W'(s2_in), W'(exp_s2));
    chk("state_out", state_out, exp_state);
`endif
  end

  // Called just after a negedge; optionally drives start/state_in noise while busy.
  task automatic wait_done(input int acc, input bit noise, input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (done !== 1'b1 && noise) begin
        #1 start = 1'($urandom_range(0, 1)); state_in = rand_state();
      end
    end
    checks++;
    if (done !== 1'b1 || cyc - acc != 18) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (done=%b) expected 18", nm, cyc - acc, done);
    end
  endtask

  initial begin
    int acc, ndone;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_done", W'(done), W'(0));
    chk("rst_state", state_out, '0);
    #1 rst_n = 1'b1;

    // Directed run with known vector.
    state_in = {128'h0, 64'h0123456789ABCDEF};
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0; acc = cyc; state_in = rand_state();
    @(negedge clk);
    @(negedge clk);
    chk("s1_first", W'(s1_in[3:0]), W'(4'hF));
    #1 start = 1'b1;
    @(negedge clk);
    chk("s1_second", W'(s1_in[3:0]), W'(4'hE));
    #1 start = 1'b0;
    wait_done(acc, 1'b0, "directed");
    chk("result_fold", W'(fold_st(state_out)), W'(64'hFEDCBA9876543210));
`ifndef TI_REMASK_EN
    chk("result", state_out, {128'h0, 64'hFEDCBA9876543210});
`endif
    // Start during DONE is ignored; held into IDLE it is accepted.
    #1 start = 1'b1; state_in = rand_state();
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0; acc = cyc;
    @(negedge clk);
    wait_done(acc, 1'b0, "idle_restart");
    @(posedge clk);

    // Reset mid-run aborts without a done pulse.
    @(negedge clk); #1 start = 1'b1; state_in = rand_state();
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_ready", W'(ready), W'(1));
    chk("abort_state", state_out, '0);
    @(negedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin @(negedge clk); if (done) ndone++; end
    chk("abort_no_done", W'(ndone), W'(0));

    // Randomized runs with busy-time start/state_in noise.
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 start = 1'b1; state_in = rand_state();
      @(posedge clk); #1 start = 1'b0; acc = cyc;
      @(negedge clk);
      wait_done(acc, 1'b1, "random");
      @(posedge clk); #1 start = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
